// File: rtl/seq_div8_pkg.sv
// Shared types for the iterative restoring divider.
// FSM state encoding used by the top level.
package seq_div8_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/seq_div8_div_step.sv
// One restoring-division iteration: shift in the next
// dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] p,
  input  logic         q_msb,
  input  logic [W-1:0] div,
  output logic [W-1:0] p_next,
  output logic         q_bit
);

  logic [W:0]   sh;
  logic [W-1:0] diff;

  assign sh = {p, q_msb};

  // When the subtract succeeds the result is below div,
  // so the low W bits carry the whole difference.
  assign diff   = sh[W-1:0] - div;
  assign q_bit  = (sh >= {1'b0, div});
  assign p_next = q_bit ? diff : sh[W-1:0];

endmodule

// File: rtl/seq_div8.sv
// Iterative unsigned 2W/W restoring divider, one
// quotient bit per clock, Start/Busy/Done handshake.
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [2*W-1:0]  Dividend,
  input  logic [W-1:0]    Divisor,
  output logic            Busy,
  output logic            Done,
  output logic [2*W-1:0]  Quotient,
  output logic [W-1:0]    Remainder,
  output logic            DivZero
);

  localparam int QW = 2 * W;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  div_q, div_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [W-1:0]  p_next;
  logic          q_bit;
  logic [QW-1:0] q_shift;

  div_step #(.W(W)) u_step (
    .p      (p_q),
    .q_msb  (q_q[QW-1]),
    .div    (div_q),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign q_shift = {q_q[QW-2:0], q_bit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    p_d     = p_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (Start) begin
          if (Divisor != '0) begin
            state_d = S_RUN;
            div_d   = Divisor;
            q_d     = Dividend;
            p_d     = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = Dividend[W-1:0];
            dz_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        q_d   = q_shift;
        p_d   = p_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          quo_d   = q_shift;
          rem_d   = p_next;
          dz_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      p_q     <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      p_q     <= p_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8 (W=8): directed
// cases, handshake corner cases and a random sweep.
module tb_seq_div8;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           Start;
  logic [2*W-1:0] Dividend;
  logic [W-1:0]   Divisor;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Quotient;
  logic [W-1:0]   Remainder;
  logic           DivZero;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  seq_div8 #(.W(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivZero   (DivZero)
  );

  // Issue one op; lat counts edges from the sampling edge
  // (inclusive) to the edge after which Done is seen.
  task automatic run_op(input logic [15:0] a,
                        input logic [7:0] b,
                        output int lat,
                        output int busy_n);
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clk);
    lat    = 1;
    busy_n = 0;
    #1;
    Start = 1'b0;
    while (!Done && lat < 40) begin
      if (Busy) busy_n++;
      @(posedge Clk);
      lat++;
      #1;
    end
  endtask

  task automatic test_reset;
    Rst   = 1'b1;
    Start = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b dz=%b required 0 0 0",
               Busy, Done, DivZero);
    end
    checks++;
    if (Quotient !== 16'd0 || Remainder !== 8'd0) begin
      failures++;
      $display("FAIL reset_data q=%h r=%h required 0 0",
               Quotient, Remainder);
    end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [15:0] da [4];
    logic [7:0]  db [4];
    logic [15:0] eq [4];
    logic [7:0]  er [4];
    logic        ez [4];
    int          el [4];
    int          eb [4];
    int lat, bn;
    da = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'h1234};
    db = '{8'd7,     8'hFF,    8'h01,    8'h00};
    eq = '{16'd142,  16'h0101, 16'hFFFF, 16'hFFFF};
    er = '{8'd6,     8'h00,    8'h00,    8'h34};
    ez = '{1'b0,     1'b0,     1'b0,     1'b1};
    el = '{17, 17, 17, 1};
    eb = '{16, 16, 16, 0};
    for (int i = 0; i < 4; i++) begin
      run_op(da[i], db[i], lat, bn);
      checks++;
      if (Quotient !== eq[i] || Remainder !== er[i] ||
          DivZero !== ez[i]) begin
        failures++;
        $display("FAIL dir%0d_result q=%h r=%h dz=%b required %h %h %b",
                 i, Quotient, Remainder, DivZero, eq[i], er[i], ez[i]);
      end
      checks++;
      if (lat != el[i]) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d required=%0d",
                 i, lat, el[i]);
      end
      checks++;
      if (bn != eb[i]) begin
        failures++;
        $display("FAIL dir%0d_busy_cycles got=%0d required=%0d",
                 i, bn, eb[i]);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (Done !== 1'b0 || Quotient !== eq[i] ||
          Remainder !== er[i]) begin
        failures++;
        $display("FAIL dir%0d_hold done=%b q=%h r=%h required 0 %h %h",
                 i, Done, Quotient, Remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge Clk);
    Dividend = 16'd100;
    Divisor  = 8'd9;
    Start    = 1'b1;
    @(posedge Clk);
    lat = 1;
    #1;
    Start = 1'b0;
    repeat (4) begin
      @(posedge Clk);
      lat++;
    end
    @(negedge Clk);
    Dividend = 16'd200;
    Divisor  = 8'd3;
    Start    = 1'b1;
    @(posedge Clk);
    lat++;
    #1;
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_busy busy=%b done=%b required 1 0",
               Busy, Done);
    end
    while (!Done && lat < 40) begin
      @(posedge Clk);
      lat++;
      #1;
    end
    checks++;
    if (Quotient !== 16'd11 || Remainder !== 8'd1 || lat != 17) begin
      failures++;
      $display("FAIL ignore_result q=%0d r=%0d lat=%0d required 11 1 17",
               Quotient, Remainder, lat);
    end
    // Still in the Done cycle: issue the next op right away.
    Dividend = 16'd50;
    Divisor  = 8'd7;
    Start    = 1'b1;
    @(posedge Clk);
    lat = 1;
    #1;
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy busy=%b done=%b required 1 0",
               Busy, Done);
    end
    while (!Done && lat < 40) begin
      @(posedge Clk);
      lat++;
      #1;
    end
    checks++;
    if (Quotient !== 16'd7 || Remainder !== 8'd1 || lat != 17) begin
      failures++;
      $display("FAIL b2b_result q=%0d r=%0d lat=%0d required 7 1 17",
               Quotient, Remainder, lat);
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    @(negedge Clk);
    Dividend = 16'd1000;
    Divisor  = 8'd7;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Quotient !== 16'd0 ||
        Remainder !== 8'd0 || DivZero !== 1'b0) begin
      failures++;
      $display("FAIL midreset busy=%b done=%b q=%h r=%h dz=%b required all 0",
               Busy, Done, Quotient, Remainder, DivZero);
    end
    dn = 0;
    repeat (30) begin
      @(posedge Clk);
      #1;
      if (Done) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midreset_no_done pulses=%0d required=0", dn);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] xq;
    logic [7:0]  xr;
    logic        xz;
    int          xl;
    int lat, bn;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      if (i % 8 == 3) b = 8'($urandom_range(1, 3));
      if (i % 16 == 5) a = 16'($urandom_range(0, 20));
      if (i % 50 == 7) b = 8'd0;
      if (b == 8'd0) begin
        xq = 16'hFFFF;
        xr = a[7:0];
        xz = 1'b1;
        xl = 1;
      end else begin
        xq = a / b;
        xr = 8'(a % b);
        xz = 1'b0;
        xl = 17;
      end
      run_op(a, b, lat, bn);
      checks++;
      if (Quotient !== xq || Remainder !== xr || DivZero !== xz) begin
        failures++;
        $display("FAIL rnd%0d %h/%h q=%h r=%h dz=%b required %h %h %b",
                 i, a, b, Quotient, Remainder, DivZero, xq, xr, xz);
      end
      checks++;
      if (lat != xl) begin
        failures++;
        $display("FAIL rnd%0d_latency got=%0d required=%0d", i, lat, xl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
